// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 2-flop line synchronizer, free-running sample tick,
// mid-bit sampling FSM and a one-word hold register with valid/ready handshake.
module uart_rx_oversample #(
  parameter int DATA_SIZE  = 8,
  parameter int SYS_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int SAMPLE     = 16,
  parameter int BAUD_DVSR  = SYS_FREQ / (SAMPLE * BAUD_RATE),
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_data_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 break_error,
  output logic                 overflow_error,
  output logic                 busy
);

  localparam int unsigned TICK_W = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
  localparam int unsigned SAMP_W = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
  localparam int unsigned BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(BAUD_DVSR - 1);
  localparam logic [SAMP_W-1:0] SAMP_MAX = SAMP_W'(SAMPLE - 1);
  localparam logic [SAMP_W-1:0] SAMP_MID = SAMP_W'(SAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [SAMP_W-1:0]      samp_cnt_q, samp_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   par_err_q, par_err_d;
  logic [DATA_SIZE-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   serr_q, serr_d;
  logic                   brk_q, brk_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;

  logic line;
  logic tick;
  logic complete;

  assign line = sync_q[1];
  assign tick = (tick_cnt_q == TICK_MAX);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      brk_q      <= brk_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, counters and hold-register logic
  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], serial_data_in};
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    serr_d     = serr_q;
    brk_d      = brk_q;
    ovf_d      = 1'b0;
    complete   = 1'b0;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!line) begin
            state_d    = ST_START;
            samp_cnt_d = '0;
          end
        end
        ST_START: begin
          // A start bit that is high again at mid-bit was only a glitch
          if (samp_cnt_q == SAMP_MID) begin
            if (line) begin
              state_d = ST_IDLE;
            end else begin
              samp_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = ST_DATA;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
        ST_DATA: begin
          if (samp_cnt_q == SAMP_MAX) begin
            samp_cnt_d = '0;
            shift_d    = {line, shift_q[DATA_SIZE-1:1]};
            if (bit_cnt_q == BIT_MAX) begin
              bit_cnt_d = '0;
              state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
        ST_PARITY: begin
          if (samp_cnt_q == SAMP_MAX) begin
            samp_cnt_d = '0;
            par_bit_d  = line;
            par_err_d  = (^shift_q) ^ line ^ 1'(PARITY_ODD);
            state_d    = ST_STOP;
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
        ST_STOP: begin
          if (samp_cnt_q == SAMP_MAX) begin
            samp_cnt_d = '0;
            complete   = 1'b1;
            state_d    = line ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            samp_cnt_d = samp_cnt_q + SAMP_W'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (line) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A completed frame loads only if the hold register is free this cycle
    if (complete) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        perr_d  = (PARITY_EN != 0) ? par_err_q : 1'b0;
        serr_d  = !line;
        brk_d   = (shift_q == '0) && !line && ((PARITY_EN == 0) || !par_bit_q);
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign data_out       = data_q;
  assign rx_valid       = valid_q;
  assign parity_error   = perr_q;
  assign stop_error     = serr_q;
  assign break_error    = brk_q;
  assign overflow_error = ovf_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: directed frame table, corner-case
// sequences (break, glitch, overflow, mid-frame reset) and random frames vs a model.
module tb_uart_rx_oversample;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_data_in;
  logic       rx_ready;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       parity_error;
  logic       stop_error;
  logic       break_error;
  logic       overflow_error;
  logic       busy;

  uart_rx_oversample #(
    .DATA_SIZE (8),
    .SAMPLE    (16),
    .BAUD_DVSR (4),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_data_in(serial_data_in),
    .data_out      (data_out),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .parity_error  (parity_error),
    .stop_error    (stop_error),
    .break_error   (break_error),
    .overflow_error(overflow_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    logic       brk;
  } rx_t;

  typedef struct {
    logic [7:0] d;
    logic       flip;
    logic       stop_b;
    rx_t        exp;
  } vec_t;

  rx_t mon_q[$];
  int  tests = 0;
  int  failed = 0;
  int  valid_cycles = 0;
  int  ovf_cycles = 0;
  int  ovf_pulses = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_ovf = 1'b0;

  // Records every newly loaded word and counts valid / overflow activity
  always @(negedge clk) begin
    if (rx_valid && (!prev_valid || prev_ready))
      mon_q.push_back({data_out, parity_error, stop_error, break_error});
    if (rx_valid) valid_cycles++;
    if (overflow_error) ovf_cycles++;
    if (overflow_error && !prev_ovf) ovf_pulses++;
    prev_valid = rx_valid;
    prev_ready = rx_ready;
    prev_ovf   = overflow_error;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_data_in = b;
    wait_clks(BIT_CLKS);
  endtask

  // Even-parity framing; par_flip corrupts the parity bit
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b,
                            input int idle_bits);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ par_flip);
    send_bit(stop_b);
    repeat (idle_bits) send_bit(1'b1);
  endtask

  function automatic rx_t model(input logic [7:0] d, input logic par_flip, input logic stop_b);
    rx_t r;
    int  ones;
    logic par;
    ones   = $countones(d);
    par    = ((ones % 2) == 1) ^ par_flip;
    r.data = d;
    r.perr = ((ones + int'(par)) % 2) != 0;
    r.serr = !stop_b;
    r.brk  = (d == 8'h00) && !par && !stop_b;
    return r;
  endfunction

  task automatic check_rx(input string name, input rx_t exp);
    int  n;
    rx_t r;
    n = 0;
    while (mon_q.size() == 0 && n < 3 * BIT_CLKS) begin
      @(posedge clk);
      n++;
    end
    if (mon_q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s: no word delivered within %0d clk, expected data 0x%0h", name, n, exp.data);
    end else begin
      r = mon_q.pop_front();
      chk({name, " data"}, 32'(r.data), 32'(exp.data));
      chk({name, " parity_error"}, 32'(r.perr), 32'(exp.perr));
      chk({name, " stop_error"}, 32'(r.serr), 32'(exp.serr));
      chk({name, " break_error"}, 32'(r.brk), 32'(exp.brk));
    end
  endtask

  initial begin
    vec_t       tbl[7];
    int         base_a;
    int         base_b;
    logic [7:0] d;
    logic       flip;
    logic       stop_b;

    tbl[0] = '{8'hB3, 1'b0, 1'b1, rx_t'({8'hB3, 3'b000})};
    tbl[1] = '{8'h5C, 1'b1, 1'b1, rx_t'({8'h5C, 3'b100})};
    tbl[2] = '{8'h00, 1'b0, 1'b1, rx_t'({8'h00, 3'b000})};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, rx_t'({8'hFF, 3'b010})};
    tbl[4] = '{8'h00, 1'b0, 1'b0, rx_t'({8'h00, 3'b011})};
    tbl[5] = '{8'h80, 1'b1, 1'b0, rx_t'({8'h80, 3'b110})};
    tbl[6] = '{8'h00, 1'b1, 1'b0, rx_t'({8'h00, 3'b110})};

    serial_data_in = 1'b1;
    rx_ready       = 1'b1;
    reset          = 1'b1;
    wait_clks(5);
    chk("reset rx_valid", 32'(rx_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset data_out", 32'(data_out), 0);
    chk("reset parity_error", 32'(parity_error), 0);
    chk("reset stop_error", 32'(stop_error), 0);
    chk("reset break_error", 32'(break_error), 0);
    chk("reset overflow_error", 32'(overflow_error), 0);
    reset = 1'b0;
    wait_clks(2 * BIT_CLKS);
    chk("idle busy", 32'(busy), 0);

    // Directed frame table
    for (int i = 0; i < 7; i++) begin
      base_a = valid_cycles;
      send_frame(tbl[i].d, tbl[i].flip, tbl[i].stop_b, 2);
      check_rx($sformatf("table[%0d]", i), tbl[i].exp);
      if (i == 0) chk("B3 rx_valid width", 32'(valid_cycles - base_a), 1);
    end

    // Line held low for 12 bit times
    serial_data_in = 1'b0;
    wait_clks(11 * BIT_CLKS + BIT_CLKS / 2);
    chk("break busy while low", 32'(busy), 1);
    chk("break single word while low", 32'(mon_q.size()), 1);
    wait_clks(BIT_CLKS / 2);
    serial_data_in = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("break busy after high", 32'(busy), 0);
    check_rx("break", rx_t'({8'h00, 3'b011}));
    chk("break no extra word", 32'(mon_q.size()), 0);

    // 20-clk low glitch in IDLE
    serial_data_in = 1'b0;
    wait_clks(12);
    chk("glitch busy rises", 32'(busy), 1);
    wait_clks(8);
    serial_data_in = 1'b1;
    wait_clks(BIT_CLKS - 20);
    chk("glitch busy falls", 32'(busy), 0);
    chk("glitch rx_valid", 32'(rx_valid), 0);
    wait_clks(BIT_CLKS);
    chk("glitch no word", 32'(mon_q.size()), 0);

    // Overflow: second frame dropped while the first is held
    rx_ready = 1'b0;
    base_a   = ovf_pulses;
    base_b   = ovf_cycles;
    send_frame(8'hAE, 1'b0, 1'b1, 1);
    send_frame(8'h11, 1'b0, 1'b1, 2);
    check_rx("overflow held", rx_t'({8'hAE, 3'b000}));
    chk("overflow single word", 32'(mon_q.size()), 0);
    chk("overflow data_out held", 32'(data_out), 32'h0000_00AE);
    chk("overflow rx_valid held", 32'(rx_valid), 1);
    chk("overflow pulse count", 32'(ovf_pulses - base_a), 1);
    chk("overflow pulse width", 32'(ovf_cycles - base_b), 1);
    rx_ready = 1'b1;
    wait_clks(2);
    chk("overflow rx_valid cleared", 32'(rx_valid), 0);
    chk("overflow no late word", 32'(mon_q.size()), 0);

    // Reset during the fourth data bit, then a clean frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    serial_data_in = 1'b1;
    wait_clks(BIT_CLKS / 2);
    chk("midframe busy", 32'(busy), 1);
    reset = 1'b1;
    wait_clks(3);
    chk("midframe reset busy", 32'(busy), 0);
    chk("midframe reset rx_valid", 32'(rx_valid), 0);
    reset = 1'b0;
    wait_clks(2 * BIT_CLKS);
    chk("midframe aborted no word", 32'(mon_q.size()), 0);
    send_frame(8'h3C, 1'b0, 1'b1, 2);
    check_rx("after reset", rx_t'({8'h3C, 3'b000}));
    chk("after reset single word", 32'(mon_q.size()), 0);

    // Random frames against the reference model
    for (int k = 0; k < 20; k++) begin
      d      = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      flip   = ($urandom_range(0, 3) == 0);
      stop_b = ($urandom_range(0, 4) != 0);
      send_frame(d, flip, stop_b, 1);
      check_rx($sformatf("random[%0d]", k), model(d, flip, stop_b));
    end
    chk("random no stray word", 32'(mon_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
